// File: rtl/div_ctrl.sv
// Multi-cycle 32-bit integer divide/remainder unit for the DIV/DIVU/REM/REMU family.
// Restoring division, one quotient bit per cycle. Zero-divisor and signed overflow results are produced directly.
module div_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] result_q, result_d;

  logic        signed_op;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        ovf;
  logic [32:0] rem_sh, diff;
  logic [31:0] rem_nx, quo_nx;
  logic [31:0] fin_q, fin_r, fin;

  always_comb begin
    signed_op = ~op_i[0];
    a_neg     = signed_op & dividend_i[31];
    b_neg     = signed_op & divisor_i[31];
    a_mag     = a_neg ? (~dividend_i + 32'd1) : dividend_i;
    b_mag     = b_neg ? (~divisor_i + 32'd1) : divisor_i;
    ovf       = signed_op && (dividend_i == 32'h8000_0000) && (divisor_i == 32'hFFFF_FFFF);
  end

  // The quotient register starts as the dividend magnitude and shifts its bits into the partial remainder.
  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    diff   = rem_sh - {1'b0, dvsr_q};
    if (!diff[32]) begin
      rem_nx = diff[31:0];
      quo_nx = {quo_q[30:0], 1'b1};
    end else begin
      rem_nx = rem_sh[31:0];
      quo_nx = {quo_q[30:0], 1'b0};
    end
    fin_q = (qneg_q && !op_q[0]) ? (~quo_nx + 32'd1) : quo_nx;
    fin_r = (rneg_q && !op_q[0]) ? (~rem_nx + 32'd1) : rem_nx;
    fin   = op_q[1] ? fin_r : fin_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          op_d   = op_i;
          qneg_d = dividend_i[31] ^ divisor_i[31];
          rneg_d = dividend_i[31];
          rem_d  = '0;
          quo_d  = a_mag;
          dvsr_d = b_mag;
          if (divisor_i == 32'd0) begin
            result_d = op_i[1] ? dividend_i : '1;
            state_d  = S_DONE;
          end else if (ovf) begin
            result_d = op_i[1] ? '0 : 32'h8000_0000;
            state_d  = S_DONE;
          end else begin
            cnt_d   = 5'd31;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          if (cnt_q == 5'd0) begin
            result_d = fin;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    ready_o  = (state_q == S_IDLE);
    busy_o   = (state_q == S_BUSY);
    valid_o  = (state_q == S_DONE);
    result_o = result_q;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The module SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 The module SHALL have the following ports:
  clk_i  input  1  clock; all state updates on rising edge
  rst_i  input  1  synchronous active-high reset
  start_i  input  1  request a divide/remainder operation
  op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (equal to funct3[1:0])
  dividend_i  input  32  rs1 operand
  divisor_i  input  32  rs2 operand
  flush_i  input  1  abort any operation in flight
  ready_o  output  1  high only in IDLE; start_i is accepted only when ready_o=1
  busy_o  output  1  high in BUSY; the pipeline uses it to stall
  valid_o  output  1  one-cycle pulse when result_o is new
  result_o  output  32  quotient or remainder

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-004 Acceptance SHALL occur in cycle N when state=IDLE, start_i=1 and flush_i=0. On acceptance the block SHALL latch op_i, the operands and the sign flags.
REQ-005 On acceptance with divisor_i=0, the next state SHALL be DONE (valid_o in cycle N+1).
  - DIV/DIVU result: 0xFFFFFFFF.
  - REM/REMU result: dividend_i.
REQ-006 On acceptance of DIV/REM with dividend_i=0x80000000 and divisor_i=0xFFFFFFFF, the next state SHALL be DONE (valid_o in cycle N+1).
  - DIV result: 0x80000000.
  - REM result: 0.
REQ-007 Otherwise the next state SHALL be BUSY, with the 5-bit iteration counter loaded to 31.
REQ-008 For signed ops, the operands SHALL be converted to magnitudes at acceptance.
  - Quotient sign: XOR of the operand signs.
  - Remainder sign: sign of the dividend.
REQ-009 BUSY SHALL perform one restoring-division step per cycle.
  - Shift the remainder/quotient pair left by 1.
  - Subtract the divisor magnitude from the 33-bit partial remainder.
  - Keep the difference and set the quotient bit when the difference is non-negative.
  - Decrement the counter.
REQ-010 After the step taken with counter=0, BUSY SHALL go to DONE. BUSY SHALL last exactly 32 cycles (N+1..N+32) and valid_o SHALL assert in cycle N+33.
REQ-011 In DONE, valid_o SHALL be 1 for exactly one cycle and result_o SHALL carry the sign-corrected quotient (DIV/DIVU) or remainder (REM/REMU). The next state SHALL be IDLE unconditionally.
REQ-012 start_i SHALL be ignored in BUSY and DONE; a start in DONE is not queued. Operand inputs SHALL be ignored outside the acceptance cycle.
REQ-013 flush_i=1 in BUSY or DONE SHALL force IDLE in the next cycle with valid_o=0 and result_o unchanged. flush_i=1 in IDLE SHALL block acceptance.
REQ-014 result_o SHALL hold its last completed value until the next DONE.
REQ-015 Outputs by state:
  - ready_o = (state==IDLE).
  - busy_o = (state==BUSY).
  - valid_o = (state==DONE).
REQ-016 A zero dividend with a nonzero divisor SHALL take the normal 32-cycle path and return 0.

Reset
REQ-017 rst_i=1 SHALL, on the next rising edge and regardless of state, set:
  - state IDLE and counter 0;
  - ready_o=1, busy_o=0, valid_o=0;
  - result_o=0x00000000;
  - all operand/partial registers to 0.
REQ-018 rst_i SHALL take priority over flush_i and start_i. An operation in flight at reset SHALL be discarded and SHALL produce no valid_o.

Verification
REQ-019 DIVU: 100 / 7, start at N -> busy_o N+1..N+32, valid_o at N+33, result_o=14. Repeat with REMU -> result_o=2.
REQ-020 Signed: DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIV 7 / 0xFFFFFFFE -> 0xFFFFFFFD.
REQ-021 Divide by zero:
  - DIV 5 / 0 -> valid_o at N+1, result 0xFFFFFFFF, busy_o never asserted.
  - REMU 5 / 0 -> result 5.
REQ-022 Overflow:
  - DIV 0x80000000 / 0xFFFFFFFF -> valid_o at N+1, result 0x80000000.
  - REM with the same operands -> result 0.
REQ-023 Flush and restart:
  - Start DIVU 1000 / 3 at N, flush_i at N+10 -> IDLE at N+11, no valid_o, result_o unchanged.
  - Start_i at N+11 accepted; result 333 at N+44.
  - Start_i pulsed during BUSY is ignored.
REQ-024 Reset mid-operation: rst_i at N+20 -> at N+21 ready_o=1, busy_o=0, valid_o=0, result_o=0, and no valid_o pulse afterwards.
